jtag_uart_stream_decoder: RTL and testbench
===========================================

JTAG_UART_STREAM_DECODER -- requirements
Module: jtag_uart_stream_decoder

Interface
REQ-001 Parameter FRAME_BYTES_LOG2, default 20, log2 of bytes per frame (2^20 = 1 MiB frame).
REQ-002 Parameter FRAME_IDX_W, default 6, frame-count field width; max frames = 2^FRAME_IDX_W.
REQ-003 Parameter ESC_BYTE, default 8'hFE, escape character.
REQ-004 iCLK  in  1  sole clock; all logic rising-edge.
REQ-005 iRST  in  1  synchronous, active-high reset.
REQ-006 oJTAG_SLAVE_ADDR  out  1  Avalon address; constant 0 (data register).
REQ-007 oJTAG_SLAVE_RDREQ  out  1  Avalon read request.
REQ-008 iJTAG_SLAVE_RDDATA  in  32  read data; [15] RVALID, [7:0] byte.
REQ-009 oJTAG_SLAVE_WRREQ  out  1  Avalon write request.
REQ-010 oJTAG_SLAVE_WRDATA  out  32  write data; [7:0] status byte, [31:8] zero.
REQ-011 iJTAG_SLAVE_WAIT  in  1  Avalon waitrequest.
REQ-012 oPIX_DATA  out  8  payload byte.
REQ-013 oPIX_VALID  out  1  payload byte valid.
REQ-014 iPIX_READY  in  1  downstream accepts; transfer when oPIX_VALID && iPIX_READY.
REQ-015 oNUM_IMAGES  out  FRAME_IDX_W+1  frames in current load.
REQ-016 oTRIGGER_WRITE_SDRAM  out  1  one-cycle pulse at load start.
REQ-017 oBUSY  out  1  high in TRIGGER, RECV, WAIT_ACK.
REQ-018 oERROR  out  1  high in ERROR state.

Function
REQ-019 Byte received = cycle with RDREQ && !WAIT && RDDATA[15]; RDDATA[15]=0 reads discarded.
REQ-020 RDREQ high iff not reset, state != TRIGGER, output register empty (oPIX_VALID=0), no write pending.
REQ-021 Escape flag: set on unescaped ESC_BYTE; next received byte is escaped and clears flag.
REQ-022 Escaped codes: 8'h00 = ABORT, 8'h01 = ACK, ESC_BYTE = literal data ESC_BYTE, other = ERROR event.
REQ-023 States: IDLE, TRIGGER, RECV, WAIT_ACK, ERROR; reset state IDLE.
REQ-024 IDLE/ERROR: unescaped 2'b10 + n[5:0] -> latch oNUM_IMAGES = n[FRAME_IDX_W-1:0]+1 (zero-extended), clear byte counter, go TRIGGER; ACK/ABORT ignored (ERROR: ABORT -> IDLE); any other byte -> ERROR.
REQ-025 TRIGGER: one cycle; oTRIGGER_WRITE_SDRAM=1; unconditionally -> RECV.
REQ-026 RECV: unescaped non-ESC byte or literal ESC_BYTE is payload: loads output register, oPIX_VALID=1 next cycle, counter +1.
REQ-027 Counter width FRAME_IDX_W+FRAME_BYTES_LOG2+1; when counter reaches oNUM_IMAGES<<FRAME_BYTES_LOG2, RECV -> WAIT_ACK next cycle; max-count (2^FRAME_IDX_W frames) counts correctly without wrap.
REQ-028 RECV: ABORT -> IDLE, counter cleared; ACK or other escape -> ERROR.
REQ-029 WAIT_ACK: ACK -> IDLE; ABORT -> IDLE; payload byte or other escape -> ERROR.
REQ-030 Output register holds byte while oPIX_VALID && !iPIX_READY; no byte ever dropped or duplicated; state changes never clear a pending output byte.
REQ-031 Latency: Avalon accept cycle N -> oPIX_VALID at N+1; next read no earlier than cycle after downstream accept.

Reset
REQ-032 iRST at any clock edge, including mid-load: state IDLE, escape flag 0, counter 0, oNUM_IMAGES 0, oPIX_VALID 0, oPIX_DATA 0, RDREQ 0, WRREQ 0, oTRIGGER_WRITE_SDRAM 0, oBUSY 0, oERROR 0.
REQ-033 First RDREQ assertion on cycle after iRST deasserts.

Configuration
REQ-034 Macro JTAG_UART_STREAM_DECODER_STATUS_ECHO_EN defined: entering WAIT_ACK queues status 8'h06, entering ERROR queues 8'h15; WRREQ held until !WAIT; RDREQ low while write pending; a new event while pending overwrites the queued byte.
REQ-035 Macro undefined: oJTAG_SLAVE_WRREQ constant 0, oJTAG_SLAVE_WRDATA constant 0, no write-pending gating of RDREQ.

Verification
REQ-036 FRAME_BYTES_LOG2=4; send 0x81 then 32 bytes, iPIX_READY=1 -> one trigger pulse, oNUM_IMAGES=2, 32 bytes out in order, WAIT_ACK; then FE 01 -> IDLE.
REQ-037 Payload FE FE in RECV -> single byte 0xFE output, counter +1.
REQ-038 iPIX_READY=0 for 10 cycles mid-load -> RDREQ low, byte held stable, no loss after release.
REQ-039 Command 0xBF (64 frames, FRAME_BYTES_LOG2=4) -> 1024 bytes then WAIT_ACK, oNUM_IMAGES=64.
REQ-040 In RECV send FE 07 -> oERROR=1; then 0x80 -> TRIGGER, oERROR=0; with STATUS_ECHO_EN, WRDATA=0x15 written once.
REQ-041 iRST pulse mid-RECV with oPIX_VALID=1 -> all outputs per REQ-032 next cycle.

Source files
------------

// File: rtl/jtag_uart_stream_decoder.sv
// Decodes an escaped JTAG-UART byte stream into frame payload bytes with load/ack framing.
// Optional host status echo is enabled by defining JTAG_UART_STREAM_DECODER_STATUS_ECHO_EN.
module jtag_uart_stream_decoder #(
  parameter int         FRAME_BYTES_LOG2 = 20,
  parameter int         FRAME_IDX_W      = 6,
  parameter logic [7:0] ESC_BYTE         = 8'hFE
) (
  input  logic                   iCLK,
  input  logic                   iRST,
  output logic                   oJTAG_SLAVE_ADDR,
  output logic                   oJTAG_SLAVE_RDREQ,
  input  logic [31:0]            iJTAG_SLAVE_RDDATA,
  output logic                   oJTAG_SLAVE_WRREQ,
  output logic [31:0]            oJTAG_SLAVE_WRDATA,
  input  logic                   iJTAG_SLAVE_WAIT,
  output logic [7:0]             oPIX_DATA,
  output logic                   oPIX_VALID,
  input  logic                   iPIX_READY,
  output logic [FRAME_IDX_W:0]   oNUM_IMAGES,
  output logic                   oTRIGGER_WRITE_SDRAM,
  output logic                   oBUSY,
  output logic                   oERROR
);

  localparam int         CNT_W      = FRAME_IDX_W + FRAME_BYTES_LOG2 + 1;
  localparam logic [7:0] CODE_ABORT = 8'h00;
  localparam logic [7:0] CODE_ACK   = 8'h01;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIGGER,
    S_RECV,
    S_WAIT_ACK,
    S_ERROR
  } state_t;

  typedef enum logic [2:0] {
    EV_NONE,
    EV_DATA,      // unescaped non-escape byte, or escaped literal ESC_BYTE
    EV_ABORT,
    EV_ACK,
    EV_BAD_ESC
  } rx_event_t;

  state_t              state, next_state;
  rx_event_t           rx_event;
  logic                rdreq, byte_rx, is_cmd, esc_pending;
  logic                load_cmd, push_pix, clr_cnt, wr_pending;
  logic [7:0]          rx_byte, pix_data;
  logic                pix_valid;
  logic [FRAME_IDX_W:0] num_images, cmd_frames;
  logic [CNT_W-1:0]    byte_cnt, target_cnt;
  logic                unused_rddata;

  assign rx_byte       = iJTAG_SLAVE_RDDATA[7:0];
  assign unused_rddata = ^{iJTAG_SLAVE_RDDATA[31:16], iJTAG_SLAVE_RDDATA[14:8]};

  // A read is only offered when the single-entry output register is free.
  assign rdreq   = ~iRST & (state != S_TRIGGER) & ~pix_valid & ~wr_pending;
  assign byte_rx = rdreq & ~iJTAG_SLAVE_WAIT & iJTAG_SLAVE_RDDATA[15];

  assign cmd_frames = {1'b0, FRAME_IDX_W'(rx_byte[5:0])} + {{FRAME_IDX_W{1'b0}}, 1'b1};
  assign target_cnt = CNT_W'(num_images) << FRAME_BYTES_LOG2;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    rx_event = EV_NONE;
    is_cmd   = 1'b0;
    if (byte_rx) begin
      if (esc_pending) begin
        if (rx_byte == CODE_ABORT)    rx_event = EV_ABORT;
        else if (rx_byte == CODE_ACK) rx_event = EV_ACK;
        else if (rx_byte == ESC_BYTE) rx_event = EV_DATA;
        else                          rx_event = EV_BAD_ESC;
      end else if (rx_byte != ESC_BYTE) begin
        rx_event = EV_DATA;
        is_cmd   = (rx_byte[7:6] == 2'b10);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge iCLK) begin
    if (iRST)         esc_pending <= 1'b0;
    else if (byte_rx) esc_pending <= ~esc_pending & (rx_byte == ESC_BYTE);
  end

  always_ff @(posedge iCLK) begin
    if (iRST) state <= S_IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    load_cmd   = 1'b0;
    push_pix   = 1'b0;
    clr_cnt    = 1'b0;
    case (state)
      S_IDLE, S_ERROR: begin
        if (rx_event == EV_DATA && is_cmd) begin
          load_cmd   = 1'b1;
          next_state = S_TRIGGER;
        end else if (rx_event == EV_ABORT) begin
          next_state = S_IDLE;
        end else if (rx_event == EV_DATA || rx_event == EV_BAD_ESC) begin
          next_state = S_ERROR;
        end
      end
      S_TRIGGER: next_state = S_RECV;
      S_RECV: begin
        if (byte_cnt == target_cnt) begin
          next_state = S_WAIT_ACK;
        end else begin
          case (rx_event)
            EV_DATA:  push_pix = 1'b1;
            EV_ABORT: begin
              next_state = S_IDLE;
              clr_cnt    = 1'b1;
            end
            EV_ACK, EV_BAD_ESC: next_state = S_ERROR;
            default: ;
          endcase
        end
      end
      S_WAIT_ACK: begin
        case (rx_event)
          EV_ACK, EV_ABORT:    next_state = S_IDLE;
          EV_DATA, EV_BAD_ESC: next_state = S_ERROR;
          default: ;
        endcase
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST || clr_cnt || load_cmd) byte_cnt <= '0;
    else if (push_pix)               byte_cnt <= byte_cnt + CNT_W'(1);
  end

  always_ff @(posedge iCLK) begin
    if (iRST)          num_images <= '0;
    else if (load_cmd) num_images <= cmd_frames;
  end

  // Pending byte survives any state change; only a downstream accept frees it.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      pix_valid <= 1'b0;
      pix_data  <= '0;
    end else if (push_pix) begin
      pix_valid <= 1'b1;
      pix_data  <= rx_byte;
    end else if (iPIX_READY) begin
      pix_valid <= 1'b0;
    end
  end

`ifdef JTAG_UART_STREAM_DECODER_STATUS_ECHO_EN
  localparam logic [7:0] STATUS_ACK = 8'h06;
  localparam logic [7:0] STATUS_ERR = 8'h15;

  logic [7:0] wr_byte;

  // A fresh status event replaces any byte still waiting for the host.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      wr_pending <= 1'b0;
      wr_byte    <= '0;
    end else if (next_state == S_WAIT_ACK && state != S_WAIT_ACK) begin
      wr_pending <= 1'b1;
      wr_byte    <= STATUS_ACK;
    end else if (next_state == S_ERROR && state != S_ERROR) begin
      wr_pending <= 1'b1;
      wr_byte    <= STATUS_ERR;
    end else if (!iJTAG_SLAVE_WAIT) begin
      wr_pending <= 1'b0;
    end
  end

  assign oJTAG_SLAVE_WRREQ  = wr_pending;
  assign oJTAG_SLAVE_WRDATA = {24'h0, wr_byte};
`else
  assign wr_pending         = 1'b0;
  assign oJTAG_SLAVE_WRREQ  = 1'b0;
  assign oJTAG_SLAVE_WRDATA = '0;
`endif

  assign oJTAG_SLAVE_ADDR     = 1'b0;
  assign oJTAG_SLAVE_RDREQ    = rdreq;
  assign oPIX_DATA            = pix_data;
  assign oPIX_VALID           = pix_valid;
  assign oNUM_IMAGES          = num_images;
  assign oTRIGGER_WRITE_SDRAM = (state == S_TRIGGER);
  assign oBUSY                = (state == S_TRIGGER) || (state == S_RECV) || (state == S_WAIT_ACK);
  assign oERROR               = (state == S_ERROR);

endmodule

// File: tb/tb_jtag_uart_stream_decoder.sv
// Randomized bench for jtag_uart_stream_decoder: host byte source, downstream sink, payload model.
module tb_jtag_uart_stream_decoder;

  localparam int FBL = 4;
  localparam int FIW = 6;

  logic          iCLK, iRST;
  logic          oJTAG_SLAVE_ADDR, oJTAG_SLAVE_RDREQ, oJTAG_SLAVE_WRREQ, iJTAG_SLAVE_WAIT;
  logic [31:0]   iJTAG_SLAVE_RDDATA, oJTAG_SLAVE_WRDATA;
  logic [7:0]    oPIX_DATA;
  logic          oPIX_VALID, iPIX_READY, oTRIGGER_WRITE_SDRAM, oBUSY, oERROR;
  logic [FIW:0]  oNUM_IMAGES;

  int errors = 0;
  int checks = 0;
  int trig_cnt = 0;
  int wait_pct = 0;
  int ready_pct = 100;
  bit force_ready_low = 1'b0;
  logic [7:0] host_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] wr_log[$];

  jtag_uart_stream_decoder #(.FRAME_BYTES_LOG2(FBL), .FRAME_IDX_W(FIW), .ESC_BYTE(8'hFE)) dut (
    .iCLK(iCLK), .iRST(iRST),
    .oJTAG_SLAVE_ADDR(oJTAG_SLAVE_ADDR), .oJTAG_SLAVE_RDREQ(oJTAG_SLAVE_RDREQ),
    .iJTAG_SLAVE_RDDATA(iJTAG_SLAVE_RDDATA), .oJTAG_SLAVE_WRREQ(oJTAG_SLAVE_WRREQ),
    .oJTAG_SLAVE_WRDATA(oJTAG_SLAVE_WRDATA), .iJTAG_SLAVE_WAIT(iJTAG_SLAVE_WAIT),
    .oPIX_DATA(oPIX_DATA), .oPIX_VALID(oPIX_VALID), .iPIX_READY(iPIX_READY),
    .oNUM_IMAGES(oNUM_IMAGES), .oTRIGGER_WRITE_SDRAM(oTRIGGER_WRITE_SDRAM),
    .oBUSY(oBUSY), .oERROR(oERROR)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  // Host-side Avalon slave, downstream sink and observers; drive at negedge, sample 1 before posedge.
  initial begin
    logic [31:0] rd;
    iJTAG_SLAVE_WAIT   = 1'b0;
    iJTAG_SLAVE_RDDATA = '0;
    iPIX_READY         = 1'b0;
    forever begin
      @(negedge iCLK);
      iJTAG_SLAVE_WAIT = ($urandom_range(99) < wait_pct);
      rd = $urandom;
      if (host_q.size() != 0 && $urandom_range(9) != 0) begin
        rd[15]   = 1'b1;
        rd[7:0]  = host_q[0];
      end else begin
        rd[15] = 1'b0;
      end
      iJTAG_SLAVE_RDDATA = rd;
      iPIX_READY = !force_ready_low && ($urandom_range(99) < ready_pct);
      #4;
      if (oTRIGGER_WRITE_SDRAM) trig_cnt++;
      if (oJTAG_SLAVE_RDREQ && !iJTAG_SLAVE_WAIT && iJTAG_SLAVE_RDDATA[15] && host_q.size() != 0)
        void'(host_q.pop_front());
      if (oPIX_VALID && iPIX_READY) got_q.push_back(oPIX_DATA);
      if (oJTAG_SLAVE_WRREQ && !iJTAG_SLAVE_WAIT) wr_log.push_back(oJTAG_SLAVE_WRDATA[7:0]);
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  // Reference model: a payload byte is expected exactly once, in order; 0xFE travels as FE FE.
  task automatic send_payload(input logic [7:0] b);
    exp_q.push_back(b);
    if (b == 8'hFE) host_q.push_back(8'hFE);
    host_q.push_back(b);
  endtask

  task automatic start_load(input logic [7:0] cmd);
    exp_q.delete();
    got_q.delete();
    host_q.push_back(cmd);
  endtask

  task automatic drain(input int budget, input string name);
    int n = 0;
    while ((host_q.size() != 0 || oPIX_VALID) && n < budget) begin
      @(negedge iCLK);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s: stream not drained after %0d cycles (host bytes left %0d)", name, n, host_q.size());
    end
    repeat (3) @(negedge iCLK);
  endtask

  function automatic int first_diff();
    if (got_q.size() != exp_q.size()) return -2;
    foreach (exp_q[i]) if (got_q[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  task automatic test_reset();
    iRST = 1'b1;
    repeat (3) @(negedge iCLK);
    checks++;
    if (oJTAG_SLAVE_RDREQ !== 1'b0) begin errors++; $display("FAIL reset_rdreq: got %b want 0", oJTAG_SLAVE_RDREQ); end
    checks++;
    if ({oPIX_VALID, oPIX_DATA} !== 9'h0) begin errors++; $display("FAIL reset_pix: got %h want 000", {oPIX_VALID, oPIX_DATA}); end
    checks++;
    if (oNUM_IMAGES !== '0) begin errors++; $display("FAIL reset_num: got %0d want 0", oNUM_IMAGES); end
    checks++;
    if ({oBUSY, oERROR, oTRIGGER_WRITE_SDRAM} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b want 000", {oBUSY, oERROR, oTRIGGER_WRITE_SDRAM});
    end
    checks++;
    if ({oJTAG_SLAVE_ADDR, oJTAG_SLAVE_WRREQ} !== 2'b00) begin
      errors++; $display("FAIL reset_addr_wr: got %b want 00", {oJTAG_SLAVE_ADDR, oJTAG_SLAVE_WRREQ});
    end
`ifndef JTAG_UART_STREAM_DECODER_STATUS_ECHO_EN
    checks++;
    if (oJTAG_SLAVE_WRDATA !== 32'h0) begin errors++; $display("FAIL reset_wrdata: got %h want 0", oJTAG_SLAVE_WRDATA); end
`endif
    iRST = 1'b0;
    @(negedge iCLK);
    checks++;
    if (oJTAG_SLAVE_RDREQ !== 1'b1) begin errors++; $display("FAIL first_rdreq: got %b want 1", oJTAG_SLAVE_RDREQ); end
  endtask

  task automatic test_basic_load();
    int t0, d;
    wait_pct = 20; ready_pct = 100;
    t0 = trig_cnt;
    start_load(8'h81);
    for (int i = 0; i < 32; i++) send_payload((i % 8 == 3) ? 8'hFE : 8'($urandom));
    drain(2000, "basic_drain");
    checks++;
    if (trig_cnt - t0 !== 1) begin errors++; $display("FAIL basic_trigger: got %0d pulses want 1", trig_cnt - t0); end
    checks++;
    if (oNUM_IMAGES !== 7'd2) begin errors++; $display("FAIL basic_num: got %0d want 2", oNUM_IMAGES); end
    d = first_diff();
    checks++;
    if (d != -1) begin errors++; $display("FAIL basic_stream: diff at %0d, got %0d bytes want %0d", d, got_q.size(), exp_q.size()); end
    checks++;
    if ({oBUSY, oERROR} !== 2'b10) begin errors++; $display("FAIL basic_wait_ack: got busy/err %b want 10", {oBUSY, oERROR}); end
    host_q.push_back(8'hFE); host_q.push_back(8'h01);
    drain(200, "basic_ack_drain");
    checks++;
    if ({oBUSY, oERROR} !== 2'b00) begin errors++; $display("FAIL basic_ack: got busy/err %b want 00", {oBUSY, oERROR}); end
  endtask

  task automatic test_escape_literal();
    int d;
    wait_pct = 30; ready_pct = 70;
    start_load(8'h80);
    for (int i = 0; i < 15; i++) send_payload((i < 4) ? 8'hFE : 8'($urandom_range(8'hFD)));
    drain(2000, "esc_drain");
    checks++;
    if (got_q.size() !== 15 || {oBUSY, oERROR} !== 2'b10) begin
      errors++; $display("FAIL esc_partial: got %0d bytes busy/err %b want 15 bytes 10", got_q.size(), {oBUSY, oERROR});
    end
    send_payload(8'hFE);
    host_q.push_back(8'hFE); host_q.push_back(8'h01);
    drain(500, "esc_ack_drain");
    checks++;
    if ({oBUSY, oERROR} !== 2'b00) begin errors++; $display("FAIL esc_ack: got busy/err %b want 00", {oBUSY, oERROR}); end
    d = first_diff();
    checks++;
    if (d != -1) begin errors++; $display("FAIL esc_stream: diff at %0d, got %0d bytes want %0d", d, got_q.size(), exp_q.size()); end
  endtask

  task automatic test_backpressure();
    int n, d;
    logic [7:0] held;
    wait_pct = 0; ready_pct = 100;
    start_load(8'h80);
    for (int i = 0; i < 5; i++) send_payload(8'($urandom));
    drain(500, "bp_pre_drain");
    force_ready_low = 1'b1;
    for (int i = 0; i < 11; i++) send_payload(8'($urandom));
    n = 0;
    while (!oPIX_VALID && n < 100) begin @(negedge iCLK); n++; end
    checks++;
    if (n >= 100) begin errors++; $display("FAIL bp_valid: oPIX_VALID never rose, got 0 want 1"); end
    held = oPIX_DATA;
    for (int c = 0; c < 10; c++) begin
      @(negedge iCLK);
      checks++;
      if ({oJTAG_SLAVE_RDREQ, oPIX_VALID, oPIX_DATA} !== {1'b0, 1'b1, held}) begin
        errors++; $display("FAIL bp_hold cycle %0d: got rdreq/valid/data %b/%b/%h want 0/1/%h",
                           c, oJTAG_SLAVE_RDREQ, oPIX_VALID, oPIX_DATA, held);
      end
    end
    force_ready_low = 1'b0;
    drain(500, "bp_drain");
    host_q.push_back(8'hFE); host_q.push_back(8'h01);
    drain(200, "bp_ack_drain");
    d = first_diff();
    checks++;
    if (d != -1 || {oBUSY, oERROR} !== 2'b00) begin
      errors++; $display("FAIL bp_stream: diff at %0d, got %0d bytes want %0d, busy/err %b", d, got_q.size(), exp_q.size(), {oBUSY, oERROR});
    end
  endtask

  task automatic test_max_frames();
    int t0, d;
    wait_pct = 10; ready_pct = 80;
    t0 = trig_cnt;
    start_load(8'hBF);
    for (int i = 0; i < 1024; i++) send_payload(8'($urandom));
    drain(20000, "max_drain");
    checks++;
    if (oNUM_IMAGES !== 7'd64) begin errors++; $display("FAIL max_num: got %0d want 64", oNUM_IMAGES); end
    checks++;
    if (trig_cnt - t0 !== 1) begin errors++; $display("FAIL max_trigger: got %0d pulses want 1", trig_cnt - t0); end
    d = first_diff();
    checks++;
    if (d != -1) begin errors++; $display("FAIL max_stream: diff at %0d, got %0d bytes want %0d", d, got_q.size(), exp_q.size()); end
    host_q.push_back(8'hFE); host_q.push_back(8'h01);
    drain(200, "max_ack_drain");
    checks++;
    if ({oBUSY, oERROR} !== 2'b00) begin errors++; $display("FAIL max_ack: got busy/err %b want 00", {oBUSY, oERROR}); end
  endtask

  task automatic test_error();
    int t0, d;
    wait_pct = 20; ready_pct = 100;
    wr_log.delete();
    start_load(8'h80);
    for (int i = 0; i < 4; i++) send_payload(8'($urandom));
    host_q.push_back(8'hFE); host_q.push_back(8'h07);
    drain(500, "err_drain");
    checks++;
    if ({oBUSY, oERROR} !== 2'b01) begin errors++; $display("FAIL err_enter: got busy/err %b want 01", {oBUSY, oERROR}); end
    d = first_diff();
    checks++;
    if (d != -1) begin errors++; $display("FAIL err_stream: diff at %0d, got %0d bytes want %0d", d, got_q.size(), exp_q.size()); end
`ifdef JTAG_UART_STREAM_DECODER_STATUS_ECHO_EN
    checks++;
    if (wr_log.size() != 1 || wr_log[0] !== 8'h15) begin
      errors++; $display("FAIL err_echo: got %0d writes want one write of 15", wr_log.size());
    end
`endif
    host_q.push_back(8'hFE); host_q.push_back(8'h01);
    drain(200, "err_ack_drain");
    checks++;
    if ({oBUSY, oERROR} !== 2'b01) begin errors++; $display("FAIL err_ack_ignored: got busy/err %b want 01", {oBUSY, oERROR}); end
    t0 = trig_cnt;
    start_load(8'h80);
    drain(200, "err_cmd_drain");
    checks++;
    if (trig_cnt - t0 !== 1 || {oBUSY, oERROR} !== 2'b10) begin
      errors++; $display("FAIL err_recover: got %0d pulses busy/err %b want 1 pulse 10", trig_cnt - t0, {oBUSY, oERROR});
    end
    for (int i = 0; i < 16; i++) send_payload(8'($urandom));
    drain(1000, "err_load_drain");
    host_q.push_back(8'hFE); host_q.push_back(8'h01);
    drain(200, "err_load_ack");
    d = first_diff();
    checks++;
    if (d != -1 || {oBUSY, oERROR} !== 2'b00) begin
      errors++; $display("FAIL err_reload: diff at %0d, got %0d bytes want %0d, busy/err %b", d, got_q.size(), exp_q.size(), {oBUSY, oERROR});
    end
  endtask

  task automatic test_idle_events();
    wait_pct = 0; ready_pct = 100;
    host_q.push_back(8'hFE); host_q.push_back(8'h01);
    drain(100, "idle_ack");
    checks++;
    if ({oBUSY, oERROR} !== 2'b00) begin errors++; $display("FAIL idle_ack_ignored: got %b want 00", {oBUSY, oERROR}); end
    host_q.push_back(8'h41);
    drain(100, "idle_junk");
    checks++;
    if ({oBUSY, oERROR} !== 2'b01) begin errors++; $display("FAIL idle_junk: got %b want 01", {oBUSY, oERROR}); end
    host_q.push_back(8'hFE); host_q.push_back(8'h00);
    drain(100, "err_abort");
    checks++;
    if ({oBUSY, oERROR} !== 2'b00) begin errors++; $display("FAIL err_abort: got %b want 00", {oBUSY, oERROR}); end
    start_load(8'h81);
    for (int i = 0; i < 3; i++) send_payload(8'($urandom));
    host_q.push_back(8'hFE); host_q.push_back(8'h00);
    drain(300, "recv_abort");
    checks++;
    if ({oBUSY, oERROR} !== 2'b00 || got_q.size() != 3) begin
      errors++; $display("FAIL recv_abort: got busy/err %b with %0d bytes want 00 with 3", {oBUSY, oERROR}, got_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int n, t0, d;
    wait_pct = 0; ready_pct = 100;
    start_load(8'h81);
    for (int i = 0; i < 3; i++) send_payload(8'($urandom));
    drain(300, "rst_pre_drain");
    force_ready_low = 1'b1;
    for (int i = 0; i < 2; i++) send_payload(8'($urandom));
    n = 0;
    while (!oPIX_VALID && n < 100) begin @(negedge iCLK); n++; end
    checks++;
    if (n >= 100) begin errors++; $display("FAIL rst_valid: oPIX_VALID never rose, got 0 want 1"); end
    iRST = 1'b1;
    host_q.delete();
    @(negedge iCLK);
    checks++;
    if ({oJTAG_SLAVE_RDREQ, oJTAG_SLAVE_WRREQ, oPIX_VALID, oBUSY, oERROR, oTRIGGER_WRITE_SDRAM} !== 6'b0) begin
      errors++; $display("FAIL rst_mid_flags: got %b want 000000",
                         {oJTAG_SLAVE_RDREQ, oJTAG_SLAVE_WRREQ, oPIX_VALID, oBUSY, oERROR, oTRIGGER_WRITE_SDRAM});
    end
    checks++;
    if ({oPIX_DATA, oNUM_IMAGES} !== '0) begin
      errors++; $display("FAIL rst_mid_data: got data %h num %0d want 0 0", oPIX_DATA, oNUM_IMAGES);
    end
    iRST = 1'b0;
    force_ready_low = 1'b0;
    @(negedge iCLK);
    // Leave a dangling escape in RECV, then reset: the next command must be seen unescaped.
    start_load(8'h80);
    send_payload(8'h12);
    host_q.push_back(8'hFE);
    drain(300, "rst_esc_drain");
    iRST = 1'b1;
    @(negedge iCLK);
    iRST = 1'b0;
    t0 = trig_cnt;
    start_load(8'h80);
    for (int i = 0; i < 16; i++) send_payload(8'($urandom));
    drain(1000, "rst_reload_drain");
    host_q.push_back(8'hFE); host_q.push_back(8'h01);
    drain(200, "rst_reload_ack");
    d = first_diff();
    checks++;
    if (d != -1 || trig_cnt - t0 != 1 || {oBUSY, oERROR} !== 2'b00) begin
      errors++; $display("FAIL rst_reload: diff at %0d, %0d bytes want %0d, %0d pulses, busy/err %b",
                         d, got_q.size(), exp_q.size(), trig_cnt - t0, {oBUSY, oERROR});
    end
  endtask

  initial begin
    iRST = 1'b1;
    test_reset();
    test_basic_load();
    test_escape_literal();
    test_backpressure();
    test_max_frames();
    test_error();
    test_idle_events();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
